// File: rtl/mac_pkg.sv
// Shared definitions for the signed MAC bank: opcode encoding, address sizing
// and saturation-limit helpers.
package mac_pkg;

  typedef enum logic [1:0] {
    OP_CLR  = 2'd0,
    OP_LOAD = 2'd1,
    OP_MAC  = 2'd2,
    OP_MSUB = 2'd3
  } op_e;

  // Widest accumulator the limit helpers can describe.
  localparam int unsigned SAT_MAXW = 128;

  // Address width for n entries, never below 1 bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    if (r == 0) r = 1;
    return r;
  endfunction

  // Largest positive two's-complement value of width w (low w bits are valid).
  function automatic logic [SAT_MAXW-1:0] sat_pos(input int unsigned w);
    logic [SAT_MAXW-1:0] v;
    v = '0;
    for (int unsigned i = 0; i + 1 < w; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Most negative two's-complement value of width w (low w bits are valid).
  function automatic logic [SAT_MAXW-1:0] sat_neg(input int unsigned w);
    logic [SAT_MAXW-1:0] v;
    v = '0;
    v[w-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Signed W-bit add/subtract evaluated in W+1 bits, with overflow detect and
// optional clamp to the W-bit signed range.
module mac_sat_add
  import mac_pkg::*;
#(
  parameter int unsigned W   = 40,
  parameter bit          SAT = 1'b1
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] p,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         ovf
);

  localparam logic [SAT_MAXW-1:0] POS_FULL = sat_pos(W);
  localparam logic [SAT_MAXW-1:0] NEG_FULL = sat_neg(W);
  localparam logic [W-1:0]        POS      = POS_FULL[W-1:0];
  localparam logic [W-1:0]        NEG      = NEG_FULL[W-1:0];

  logic [W:0] ext;

  always_comb begin
    ext = sub ? ({acc[W-1], acc} - {p[W-1], p})
              : ({acc[W-1], acc} + {p[W-1], p});
    // Top two bits disagree exactly when the true result leaves the W-bit range;
    // ext[W] then carries the true sign and picks the clamp direction.
    ovf = ext[W] ^ ext[W-1];
    sum = ext[W-1:0];
    if (SAT && ovf) sum = ext[W] ? NEG : POS;
  end

endmodule

// File: rtl/signed_mac_bank.sv
// Bank of SIZE signed accumulators updated by a 2-stage WORD x WORD
// multiply-accumulate pipeline with valid/ready handshakes on both sides.
module signed_mac_bank
  import mac_pkg::*;
#(
  parameter int unsigned  WORD  = 16,
  parameter int unsigned  SIZE  = 8,
  parameter int unsigned  ACC_W = 40,
  parameter bit           SAT   = 1'b1,
  localparam int unsigned AW    = clog2(SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [AW-1:0]    addr,
  input  logic [WORD-1:0]  a,
  input  logic [WORD-1:0]  b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW-1:0]    out_addr,
  output logic [ACC_W-1:0] result,
  output logic             ovf
);

  if (ACC_W < 2 * WORD) begin : g_acc_too_narrow
    $error("signed_mac_bank: ACC_W must be at least 2*WORD");
  end
  if (ACC_W > SAT_MAXW) begin : g_acc_too_wide
    $error("signed_mac_bank: ACC_W exceeds SAT_MAXW");
  end

  logic signed [WORD-1:0]   a_s, b_s;
  logic signed [2*WORD-1:0] prod;

  logic             s1_valid;
  op_e              s1_op;
  logic [AW-1:0]    s1_addr;
  logic [ACC_W-1:0] s1_p;
  logic [ACC_W-1:0] s1_ld;

  logic [ACC_W-1:0] acc [SIZE];
  logic             addr_ok;
  logic [ACC_W-1:0] acc_rd;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic [ACC_W-1:0] n_val;
  logic             n_ovf;
  logic             stall;
  logic             s1_en;

  assign a_s  = a;
  assign b_s  = b;
  assign prod = (2*WORD)'(a_s) * (2*WORD)'(b_s);

  assign stall    = out_valid && !out_ready;
  assign s1_en    = !stall || !s1_valid;
  assign in_ready = s1_en;

  // Stage 2 writes acc[] on the same edge it loads result, so the next op reads
  // the updated entry directly: back-to-back same-address ops need no bypass mux.
  assign addr_ok = (32'(s1_addr) < SIZE);
  assign acc_rd  = addr_ok ? acc[s1_addr] : '0;

  mac_sat_add #(
    .W   (ACC_W),
    .SAT (SAT)
  ) u_sat_add (
    .acc (acc_rd),
    .p   (s1_p),
    .sub (s1_op == OP_MSUB),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_comb begin
    n_val = '0;
    n_ovf = 1'b0;
    unique case (s1_op)
      OP_CLR:  n_val = '0;
      OP_LOAD: n_val = s1_ld;
      OP_MAC,
      OP_MSUB: begin
        n_val = add_sum;
        n_ovf = add_ovf;
      end
    endcase
    if (!addr_ok) begin
      n_val = '0;
      n_ovf = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_op     <= OP_CLR;
      s1_addr   <= '0;
      s1_p      <= '0;
      s1_ld     <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      result    <= '0;
      ovf       <= 1'b0;
      for (int unsigned i = 0; i < SIZE; i++) acc[i] <= '0;
    end else begin
      if (s1_en) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_op   <= op_e'(op);
          s1_addr <= addr;
          s1_p    <= ACC_W'(prod);
          s1_ld   <= ACC_W'(a_s);
        end
      end
      if (!stall) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_addr <= s1_addr;
          result   <= n_val;
          ovf      <= n_ovf;
          if (addr_ok) acc[s1_addr] <= n_val;
        end
      end
    end
  end

endmodule
